q_value_serializer: RTL and testbench

Transmitter feeding the target-network max stage. It accepts one parallel vector of NUMBER_OF_OUTPUT_NODE IEEE-754 Q-values and streams it out serially, one word per cycle, node 0 first, on a valid/ready interface. It double-buffers so a second vector can be captured while the first streams. It inserts a programmable idle gap after each frame, because the downstream collector ignores the cycle following its last word.

---
 rtl/dqn_pkg.sv | 22 ++
 rtl/q_value_serializer_if.sv | 32 +++
 rtl/q_vector_bank.sv | 51 +++++
 rtl/q_value_serializer.sv | 139 +++++++++++++
 tb/tb_q_value_serializer.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dqn_pkg.sv
// dqn_pkg: definitions shared by the DQN target-network blocks.
//   DATA_WIDTH_DEF : default Q-value word width (float32)
//   ser_state_e    : serializer FSM encoding (IDLE / SEND / GAP)
//   clog2          : ceil(log2(v)), never less than 1 bit
package dqn_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } ser_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/q_value_serializer_if.sv
// q_value_serializer_if: parallel-in / serial-out bus of the Q-value serializer.
//   i_valid/i_data/o_ready : parallel vector handshake (node k at [k*DW +: DW])
//   o_data/o_valid/o_last/i_ready : serial word stream
//   o_index : node number of o_data (only with Q_SERIALIZER_INDEX_EN)
// slave modport = serializer side, master modport = environment side.
interface q_value_serializer_if #(
  parameter int DATA_WIDTH            = dqn_pkg::DATA_WIDTH_DEF,
  parameter int NUMBER_OF_OUTPUT_NODE = 3
);
  logic                                  i_valid;
  logic [DATA_WIDTH*NUMBER_OF_OUTPUT_NODE-1:0] i_data;
  logic                                  o_ready;
  logic                                  i_ready;
  logic [DATA_WIDTH-1:0]                 o_data;
  logic                                  o_valid;
  logic                                  o_last;

`ifdef Q_SERIALIZER_INDEX_EN
  logic [dqn_pkg::clog2(NUMBER_OF_OUTPUT_NODE)-1:0] o_index;

  modport slave  (input  i_valid, i_data, i_ready,
                  output o_ready, o_data, o_valid, o_last, o_index);
  modport master (output i_valid, i_data, i_ready,
                  input  o_ready, o_data, o_valid, o_last, o_index);
`else
  modport slave  (input  i_valid, i_data, i_ready,
                  output o_ready, o_data, o_valid, o_last);
  modport master (output i_valid, i_data, i_ready,
                  input  o_ready, o_data, o_valid, o_last);
`endif

endinterface

// File: rtl/q_vector_bank.sv
// q_vector_bank: two-entry store of parallel Q-value vectors.
//   push_i/data_i : write data_i into the bank at the write pointer
//   pop_i         : release the bank at the read pointer
//   ready_o       : a bank is free (decoded from the registered count)
//   count_o       : occupied banks, 0..2
//   rd_vec_o      : oldest vector, nxt_vec_o : the other bank
module q_vector_bank #(
  parameter int DATA_WIDTH            = dqn_pkg::DATA_WIDTH_DEF,
  parameter int NUMBER_OF_OUTPUT_NODE = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  logic pop_i,
  input  logic [NUMBER_OF_OUTPUT_NODE-1:0][DATA_WIDTH-1:0] data_i,
  output logic ready_o,
  output logic [1:0] count_o,
  output logic [NUMBER_OF_OUTPUT_NODE-1:0][DATA_WIDTH-1:0] rd_vec_o,
  output logic [NUMBER_OF_OUTPUT_NODE-1:0][DATA_WIDTH-1:0] nxt_vec_o
);
  logic [1:0][NUMBER_OF_OUTPUT_NODE-1:0][DATA_WIDTH-1:0] mem_q;
  logic       wr_q, wr_d, rd_q, rd_d;
  logic [1:0] cnt_q, cnt_d;

  assign wr_d  = wr_q ^ push_i;
  assign rd_d  = rd_q ^ pop_i;
  assign cnt_d = cnt_q + 2'(push_i) - 2'(pop_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Contents need no reset: a zero count already marks every bank empty.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end

  assign ready_o   = (cnt_q != 2'd2);
  assign count_o   = cnt_q;
  assign rd_vec_o  = mem_q[rd_q];
  assign nxt_vec_o = mem_q[~rd_q];

endmodule

// File: rtl/q_value_serializer.sv
// q_value_serializer: double-buffered parallel-to-serial Q-value transmitter.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : q_value_serializer_if.slave (vector in, word stream out)
// Streams node 0..N-1 of each accepted vector, one word per cycle, then
// forces FRAME_GAP idle cycles. Build option Q_SERIALIZER_INDEX_EN adds
// bus.o_index, the node number of the word on o_data.
module q_value_serializer
  import dqn_pkg::*;
#(
  parameter int DATA_WIDTH            = DATA_WIDTH_DEF,
  parameter int NUMBER_OF_OUTPUT_NODE = 3,
  parameter int FRAME_GAP             = 1
) (
  input logic clk,
  input logic rst_n,
  q_value_serializer_if.slave bus
);
  localparam int N  = NUMBER_OF_OUTPUT_NODE;
  localparam int IW = clog2(N);
  localparam int GW = clog2(FRAME_GAP + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef logic [N-1:0][DATA_WIDTH-1:0] vec_t;

  vec_t       in_vec, rd_vec, nxt_vec, head_vec;
  logic       push, pop, bank_rdy;
  logic [1:0] count, remain;

  ser_state_e            state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d, last_q, last_d;

  assign in_vec = bus.i_data;
  assign push   = bus.i_valid && bank_rdy;
  assign pop    = (state_q == ST_SEND) && bus.i_ready && last_q;

  // Vectors still queued once this cycle's pop is taken into account.
  assign remain = count - 2'(pop);
  // Source of the next frame's word 0: the oldest remaining bank, or the
  // input bus itself when the vector is only being written at this edge.
  assign head_vec = (remain != 2'd0) ? (pop ? nxt_vec : rd_vec) : in_vec;

  q_vector_bank #(
    .DATA_WIDTH           (DATA_WIDTH),
    .NUMBER_OF_OUTPUT_NODE(N)
  ) u_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_i   (push),
    .pop_i    (pop),
    .data_i   (in_vec),
    .ready_o  (bank_rdy),
    .count_o  (count),
    .rd_vec_o (rd_vec),
    .nxt_vec_o(nxt_vec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    case (state_q)
      ST_IDLE: begin
        if (remain != 2'd0 || push) begin
          state_d = ST_SEND;
          idx_d   = '0;
        end
      end
      ST_SEND: begin
        if (bus.i_ready) begin
          if (last_q) begin
            idx_d = '0;
            if (FRAME_GAP > 0) begin
              state_d = ST_GAP;
              gap_d   = GAP_LOAD;
            end else if (remain != 2'd0 || push) begin
              state_d = ST_SEND;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gap_q != '0) gap_d = gap_q - 1'b1;
        else if (remain != 2'd0 || push) state_d = ST_SEND;
        else state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs; a stalled word re-selects rd_vec[idx_q], which
  // cannot change while its bank is held.
  always_comb begin
    valid_d = 1'b0;
    last_d  = 1'b0;
    data_d  = '0;
    if (state_d == ST_SEND) begin
      valid_d = 1'b1;
      last_d  = (idx_d == LAST_IDX);
      if (state_q != ST_SEND || pop) data_d = head_vec[0];
      else data_d = rd_vec[idx_d];
    end
  end

  assign bus.o_ready = bank_rdy;
  assign bus.o_data  = data_q;
  assign bus.o_valid = valid_q;
  assign bus.o_last  = last_q;
`ifdef Q_SERIALIZER_INDEX_EN
  // idx_q returns to 0 whenever no word is on the bus.
  assign bus.o_index = idx_q;
`endif

endmodule

// File: tb/tb_q_value_serializer.sv
module tb_q_value_serializer;
  import dqn_pkg::*;

  localparam int DW  = 32;
  localparam int N   = 3;
  localparam int GAP = 1;
  localparam int IW  = clog2(N);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [N*DW-1:0] va, vb, vc;

  always #5 clk = ~clk;

  q_value_serializer_if #(.DATA_WIDTH(DW), .NUMBER_OF_OUTPUT_NODE(N)) bus ();
  q_value_serializer_if #(.DATA_WIDTH(DW), .NUMBER_OF_OUTPUT_NODE(N)) bus0 ();

  q_value_serializer #(.DATA_WIDTH(DW), .NUMBER_OF_OUTPUT_NODE(N), .FRAME_GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave));
  q_value_serializer #(.DATA_WIDTH(DW), .NUMBER_OF_OUTPUT_NODE(N), .FRAME_GAP(0)) dut_gap0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave));

  function automatic logic [DW-1:0] word(input logic [N*DW-1:0] v, input int k);
    return v[k*DW +: DW];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid got %0b exp 0", bus.o_valid); end
    checks++; if (bus.o_last !== 1'b0) begin errors++; $display("FAIL reset_o_last got %0b exp 0", bus.o_last); end
    checks++; if (bus.o_data !== '0) begin errors++; $display("FAIL reset_o_data got %h exp 0", bus.o_data); end
    checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL reset_o_ready got %0b exp 1", bus.o_ready); end
    checks++; if (bus0.o_valid !== 1'b0 || bus0.o_ready !== 1'b1) begin
      errors++; $display("FAIL reset_gap0 got valid %0b ready %0b exp 0 1", bus0.o_valid, bus0.o_ready); end
`ifdef Q_SERIALIZER_INDEX_EN
    checks++; if (bus.o_index !== '0) begin errors++; $display("FAIL reset_o_index got %0d exp 0", bus.o_index); end
`endif
    rst_n = 1'b1;
    step();
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_release_valid got %0b exp 0", bus.o_valid); end
  endtask

  task automatic test_single();
    logic ev, el;
    logic [DW-1:0] ed;
    bus.i_ready = 1'b1; bus.i_data = va; bus.i_valid = 1'b1;
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL single_pre_valid got %0b exp 0", bus.o_valid); end
    step();
    bus.i_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      ev = (c < 3); el = (c == 2); ed = (c < 3) ? word(va, c) : '0;
      checks++;
      if (bus.o_valid !== ev || bus.o_data !== ed || bus.o_last !== el) begin
        errors++; $display("FAIL single_c%0d got v%0b d%h l%0b exp v%0b d%h l%0b",
                           c, bus.o_valid, bus.o_data, bus.o_last, ev, ed, el); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic ev, el, er;
    logic [DW-1:0] ed;
    bus.i_ready = 1'b1; bus.i_data = va; bus.i_valid = 1'b1;
    step();
    for (int c = 0; c < 8; c++) begin
      ev = (c != 3 && c != 7); el = (c == 2 || c == 6); er = !(c == 1 || c == 2);
      ed = (c < 3) ? word(va, c) : (c > 3 && c < 7) ? word(vb, c - 4) : '0;
      checks++;
      if (bus.o_valid !== ev || bus.o_data !== ed || bus.o_last !== el || bus.o_ready !== er) begin
        errors++; $display("FAIL b2b_c%0d got v%0b d%h l%0b r%0b exp v%0b d%h l%0b r%0b", c,
                           bus.o_valid, bus.o_data, bus.o_last, bus.o_ready, ev, ed, el, er); end
      if (c == 0) bus.i_data = vb;
      if (c == 1) bus.i_valid = 1'b0;
      step();
    end
  endtask

  task automatic test_backpressure();
    bus.i_ready = 1'b1; bus.i_data = va; bus.i_valid = 1'b1;
    step();
    bus.i_valid = 1'b0;
    step();
    checks++; if (bus.o_data !== word(va, 1)) begin errors++; $display("FAIL bp_word1 got %h exp %h", bus.o_data, word(va, 1)); end
    bus.i_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (bus.o_valid !== 1'b1 || bus.o_data !== word(va, 1) || bus.o_last !== 1'b0) begin
        errors++; $display("FAIL bp_hold_c%0d got v%0b d%h l%0b exp v1 d%h l0", c,
                           bus.o_valid, bus.o_data, bus.o_last, word(va, 1)); end
    end
    bus.i_ready = 1'b1;
    step();
    checks++; if (bus.o_valid !== 1'b1 || bus.o_data !== word(va, 2) || bus.o_last !== 1'b1) begin
      errors++; $display("FAIL bp_word2 got v%0b d%h l%0b exp v1 d%h l1", bus.o_valid, bus.o_data, bus.o_last, word(va, 2)); end
    step();
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL bp_after got %0b exp 0", bus.o_valid); end
    step();
  endtask

  task automatic test_full_block();
    logic [DW-1:0] got[$];
    logic [DW-1:0] ew;
    int acc_c = -1;
    bit drop = 0;
    bus.i_ready = 1'b1; bus.i_data = va; bus.i_valid = 1'b1;
    step();
    for (int c = 0; c < 40 && got.size() < 3*N; c++) begin
      if (bus.o_valid) got.push_back(bus.o_data);
      if (drop) begin bus.i_valid = 1'b0; drop = 0; end
      if (c == 0) bus.i_data = vb;
      if (c == 1) begin
        bus.i_data = vc;
        checks++; if (bus.o_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0b exp 0", bus.o_ready); end
      end
      if (c >= 1 && bus.i_valid && bus.o_ready && acc_c < 0) begin acc_c = c; drop = 1; end
      step();
    end
    checks++; if (acc_c != 3) begin errors++; $display("FAIL full_accept_cycle got %0d exp 3", acc_c); end
    checks++; if (got.size() != 3*N) begin errors++; $display("FAIL full_word_count got %0d exp %0d", got.size(), 3*N); end
    for (int k = 0; k < got.size() && k < 3*N; k++) begin
      ew = (k < N) ? word(va, k) : (k < 2*N) ? word(vb, k - N) : word(vc, k - 2*N);
      checks++; if (got[k] !== ew) begin errors++; $display("FAIL full_order_w%0d got %h exp %h", k, got[k], ew); end
    end
    bus.i_valid = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_reset_mid();
    bus.i_ready = 1'b1; bus.i_data = va; bus.i_valid = 1'b1;
    step();
    bus.i_valid = 1'b0;
    checks++; if (bus.o_valid !== 1'b1 || bus.o_data !== word(va, 0)) begin
      errors++; $display("FAIL rstmid_word0 got v%0b d%h exp v1 d%h", bus.o_valid, bus.o_data, word(va, 0)); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.o_valid !== 1'b0 || bus.o_data !== '0 || bus.o_ready !== 1'b1 || bus.o_last !== 1'b0) begin
      errors++; $display("FAIL rstmid_async got v%0b d%h r%0b l%0b exp v0 d0 r1 l0",
                         bus.o_valid, bus.o_data, bus.o_ready, bus.o_last); end
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL rstmid_ghost_c%0d got v%0b d%h exp v0", c, bus.o_valid, bus.o_data); end
    end
  endtask

  task automatic test_gap0();
    logic ev, el;
    logic [DW-1:0] ed;
    bus0.i_ready = 1'b1; bus0.i_data = va; bus0.i_valid = 1'b1;
    step();
    for (int c = 0; c < 7; c++) begin
      ev = (c < 6); el = (c == 2 || c == 5);
      ed = (c < 3) ? word(va, c) : (c < 6) ? word(vb, c - 3) : '0;
      checks++;
      if (bus0.o_valid !== ev || bus0.o_data !== ed || bus0.o_last !== el) begin
        errors++; $display("FAIL gap0_c%0d got v%0b d%h l%0b exp v%0b d%h l%0b",
                           c, bus0.o_valid, bus0.o_data, bus0.o_last, ev, ed, el); end
`ifdef Q_SERIALIZER_INDEX_EN
      checks++; if (ev && bus0.o_index !== IW'(c % N)) begin
        errors++; $display("FAIL gap0_index_c%0d got %0d exp %0d", c, bus0.o_index, c % N); end
`endif
      if (c == 0) bus0.i_data = vb;
      if (c == 1) bus0.i_valid = 1'b0;
      step();
    end
  endtask

  // Reference: queue of expected words in acceptance order; a vector is
  // held from acceptance until its last word leaves.
  task automatic test_random();
    logic [DW-1:0] exp_d[$];
    bit exp_l[$];
    int exp_i[$];
    int held = 0;
    int idle = 1000;
    bit done = 0;
    logic [N*DW-1:0] v;
    for (int c = 0; c < 800 && !done; c++) begin
      checks++; if (bus.o_ready !== (held < 2)) begin
        errors++; $display("FAIL rand_ready_c%0d got %0b exp %0b", c, bus.o_ready, held < 2); end
      if (!bus.o_valid) begin
        idle++;
        checks++; if (bus.o_data !== '0) begin errors++; $display("FAIL rand_idle_data_c%0d got %h exp 0", c, bus.o_data); end
      end
      for (int k = 0; k < N; k++) v[k*DW +: DW] = $urandom;
      bus.i_data  = v;
      bus.i_valid = (c < 400) && ($urandom_range(0, 1) == 1);
      bus.i_ready = ($urandom_range(0, 3) != 0);
      if (bus.o_valid && bus.i_ready) begin
        checks++;
        if (exp_d.size() == 0) begin
          errors++; $display("FAIL rand_extra_word_c%0d got %h exp none", c, bus.o_data);
        end else begin
          if (bus.o_data !== exp_d[0] || bus.o_last !== exp_l[0]) begin
            errors++; $display("FAIL rand_word_c%0d got d%h l%0b exp d%h l%0b", c, bus.o_data, bus.o_last, exp_d[0], exp_l[0]); end
`ifdef Q_SERIALIZER_INDEX_EN
          checks++; if (bus.o_index !== IW'(exp_i[0])) begin
            errors++; $display("FAIL rand_index_c%0d got %0d exp %0d", c, bus.o_index, exp_i[0]); end
`endif
          if (exp_i[0] == 0) begin
            checks++; if (idle < GAP) begin errors++; $display("FAIL rand_gap_c%0d got %0d exp >=%0d", c, idle, GAP); end
          end
          if (exp_l[0]) begin held--; idle = 0; end
          void'(exp_d.pop_front()); void'(exp_l.pop_front()); void'(exp_i.pop_front());
        end
      end
      if (bus.i_valid && bus.o_ready) begin
        for (int k = 0; k < N; k++) begin
          exp_d.push_back(v[k*DW +: DW]); exp_l.push_back(k == N - 1); exp_i.push_back(k);
        end
        held++;
      end
      if (c >= 400 && exp_d.size() == 0) done = 1;
      step();
    end
    checks++; if (exp_d.size() != 0) begin errors++; $display("FAIL rand_drain got %0d words left exp 0", exp_d.size()); end
    bus.i_valid = 1'b0; bus.i_ready = 1'b1;
    repeat (3) step();
  endtask

  initial begin
    va = {32'hC0400000, 32'h40000000, 32'h3F800000};
    vb = {32'h40A00000, 32'h40400000, 32'hBF000000};
    vc = {32'h42C80000, 32'h3E800000, 32'h41100000};
    bus.i_valid = 1'b0; bus.i_ready = 1'b1; bus.i_data = '0;
    bus0.i_valid = 1'b0; bus0.i_ready = 1'b1; bus0.i_data = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_full_block();
    test_reset_mid();
    test_gap0();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
